// File: rtl/pipereg_hs_pkg.sv
// Shared constants for the handshaked pipeline-stage register and its users.
package pipereg_hs_pkg;

    localparam int WORD_WIDTH   = 32;
    localparam int REGFILE_BITS = 5;

    // Stage FSM encodings
    localparam logic [1:0] PHS_EMPTY = 2'd0;
    localparam logic [1:0] PHS_FULL  = 2'd1;
    localparam logic [1:0] PHS_SKID  = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = PHS_EMPTY,
        ST_FULL  = PHS_FULL,
        ST_SKID  = PHS_SKID
    } phs_state_t;

    // Default packed payload / control widths per pipeline boundary
    // IF/ID  : pc4, instr
    localparam int IF_ID_DATA_W   = 2 * WORD_WIDTH;
    localparam int IF_ID_CTRL_W   = 1;
    // ID/EXE : pc4, rs1 data, rs2 data, imm, rd
    localparam int ID_EXE_DATA_W  = 4 * WORD_WIDTH + REGFILE_BITS;
    localparam int ID_EXE_CTRL_W  = 12;
    // EXE/MEM: pc4, alu out, store data, rd
    localparam int EXE_MEM_DATA_W = 3 * WORD_WIDTH + REGFILE_BITS;
    localparam int EXE_MEM_CTRL_W = 8;
    // MEM/WB : pc4, alu out, load data, rd
    localparam int MEM_WB_DATA_W  = 3 * WORD_WIDTH + REGFILE_BITS;
    localparam int MEM_WB_CTRL_W  = 4;

    // True when the state holds at least one entry in the main slot
    function automatic logic phs_holds_entry(input phs_state_t s);
        return (s != ST_EMPTY);
    endfunction

endpackage

// File: rtl/pipereg_hs_slot.sv
// One payload+control storage slot with load enable and async clear.
module pipereg_hs_slot
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 12
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    // Capture the incoming entry when loaded; cleared on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_ctrl <= '0;
        end else if (load) begin
            out_data <= in_data;
            out_ctrl <= in_ctrl;
        end
    end

endmodule

// File: rtl/pipereg_hs.sv
// Handshaked pipeline-stage register with optional 2-entry skid buffer,
// flush, bubble control-zeroing and a saturating stall counter.
//
// state | meaning
// ------+---------------------------------------------------------------
// EMPTY | no entry held; out_valid=0, in_ready=1
// FULL  | main slot holds an entry; in_ready=1
// SKID  | main and skid slots both hold entries; in_ready=0
module pipereg_hs
#(
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 12,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              clr_cnt
);

    import pipereg_hs_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    phs_state_t        state_q;
    phs_state_t        state_d;
    logic              acc;
    logic              take;
    logic              main_load;
    logic              main_from_skid;
    logic              skid_load;
    logic              in_ready_q;
    logic [DATA_W-1:0] main_d_data;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic [DATA_W-1:0] main_q_data;
    logic [CTRL_W-1:0] main_q_ctrl;
    logic [DATA_W-1:0] skid_q_data;
    logic [CTRL_W-1:0] skid_q_ctrl;

    assign acc  = in_valid && in_ready;
    assign take = out_valid && out_ready;

    assign out_valid = phs_holds_entry(state_q);
    assign out_data  = main_q_data;
    // Bubbles never carry live control bits downstream
    assign out_ctrl  = out_valid ? main_q_ctrl : '0;

    // Refill from skid when draining it, otherwise from upstream
    assign main_d_data = main_from_skid ? skid_q_data : in_data;
    assign main_d_ctrl = main_from_skid ? skid_q_ctrl : in_ctrl;

    pipereg_hs_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk      (clk),
        .rst      (rst),
        .load     (main_load),
        .in_data  (main_d_data),
        .in_ctrl  (main_d_ctrl),
        .out_data (main_q_data),
        .out_ctrl (main_q_ctrl)
    );

    generate
        if (SKID_EN != 0) begin : g_skid
            pipereg_hs_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk      (clk),
                .rst      (rst),
                .load     (skid_load),
                .in_data  (in_data),
                .in_ctrl  (in_ctrl),
                .out_data (skid_q_data),
                .out_ctrl (skid_q_ctrl)
            );
            // Registered ready keeps backpressure off any combinational path
            assign in_ready = in_ready_q;
        end else begin : g_noskid
            logic [1:0] noskid_unused;
            assign skid_q_data   = '0;
            assign skid_q_ctrl   = '0;
            assign noskid_unused = {skid_load, in_ready_q};
            // Single entry: pass-through ready so a full stage can stream
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    // Next-state and slot-load decode; flush overrides any handshake
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        state_d   = ST_FULL;
                        main_load = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (acc && take) begin
                        main_load = 1'b1;
                    end else if (acc) begin
                        // Without skid, acc in FULL always coincides with take
                        if (SKID_EN != 0) begin
                            state_d   = ST_SKID;
                            skid_load = 1'b1;
                        end
                    end else if (take) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (take) begin
                        state_d        = ST_FULL;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Ready flop: low only while both slots are occupied
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_d != ST_SKID);
        end
    end

    // Saturating stall counter; clear wins over increment, flush leaves it alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipereg_hs.sv
// Scoreboard bench for pipereg_hs: skid instance with randomized traffic,
// plus a single-entry narrow-counter instance for directed checks.
module tb_pipereg_hs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        flush, in_valid, in_ready, out_valid, out_ready, clr_cnt;
    logic [31:0] in_data, out_data;
    logic [11:0] in_ctrl, out_ctrl;
    logic [15:0] stall_cnt;

    logic        z_flush, z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_clr_cnt;
    logic [31:0] z_in_data, z_out_data;
    logic [11:0] z_in_ctrl, z_out_ctrl;
    logic [3:0]  z_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: FIFO of accepted {ctrl,data} entries still held by the stage
    logic [43:0] sb_q[$];
    int          stall_model = 0;
    logic        m_exp_v;

    always #5 clk = ~clk;

    pipereg_hs #(.DATA_W(32), .CTRL_W(12), .SKID_EN(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl), .stall_cnt(stall_cnt), .clr_cnt(clr_cnt)
    );

    pipereg_hs #(.DATA_W(32), .CTRL_W(12), .SKID_EN(0), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .flush(z_flush), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .in_data(z_in_data), .in_ctrl(z_in_ctrl), .out_valid(z_out_valid), .out_ready(z_out_ready),
        .out_data(z_out_data), .out_ctrl(z_out_ctrl), .stall_cnt(z_stall_cnt), .clr_cnt(z_clr_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT outputs against the model, then retire/flush entries
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            stall_model = 0;
        end else begin
            m_exp_v = (sb_q.size() > 0);
            check("out_valid", 64'(out_valid), 64'(m_exp_v));
            check("in_ready", 64'(in_ready), 64'(sb_q.size() < 2));
            if (!m_exp_v) check("bubble_ctrl", 64'(out_ctrl), 64'd0);
            else          check("payload", 64'({out_ctrl, out_data}), 64'(sb_q[0]));
            check("stall_cnt", 64'(stall_cnt), 64'(stall_model));
            if (m_exp_v && out_ready) void'(sb_q.pop_front());
            if (flush) sb_q.delete();
            if (clr_cnt) stall_model = 0;
            else if (m_exp_v && !out_ready && stall_model < 65535) stall_model++;
        end
    end

    // Stimulus-side capture: every accepted entry is expected downstream in order
    always @(negedge clk) begin
        #1;
        if (!rst && in_valid && in_ready && !flush)
            sb_q.push_back({in_ctrl, in_data});
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic [11:0] c, input logic rdy);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = rdy;
    endtask

    initial begin
        flush = 0; clr_cnt = 0;
        drive(0, '0, '0, 0);
        z_flush = 0; z_in_valid = 0; z_in_data = '0; z_in_ctrl = '0; z_out_ready = 0; z_clr_cnt = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_stall", 64'(stall_cnt), 64'd0);
        rst = 0;

        // Single entry and back-to-back streaming
        drive(1, 32'hA5A5A5A5, 12'h3, 1);
        tick();
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_data", 64'(out_data), 64'hA5A5A5A5);
        check("t1_ctrl", 64'(out_ctrl), 64'h3);
        for (int i = 1; i <= 3; i++) begin
            drive(1, 32'(i), 12'(i), 1);
            tick();
            check("t1_stream_data", 64'(out_data), 64'(i));
            check("t1_stream_rdy", 64'(in_ready), 64'd1);
        end
        drive(0, '0, '0, 1);
        tick();

        // Skid fill, hold and drain
        drive(1, 32'h11, 12'hABC, 1);
        tick();
        drive(1, 32'h22, 12'h0F0, 0);
        tick();
        check("t2_in_ready", 64'(in_ready), 64'd0);
        check("t2_hold", 64'(out_data), 64'h11);
        drive(0, '0, '0, 1);
        tick();
        check("t2_second", 64'(out_data), 64'h22);
        check("t2_rdy_back", 64'(in_ready), 64'd1);
        tick();
        check("t2_empty", 64'(out_valid), 64'd0);

        // Flush while skidded, with a colliding accept
        drive(1, 32'h11, 12'hABC, 0);
        tick();
        drive(1, 32'h22, 12'h0F0, 0);
        tick();
        drive(1, 32'h33, 12'hFFF, 0);
        flush = 1;
        tick();
        flush = 0;
        check("t3_valid", 64'(out_valid), 64'd0);
        check("t3_ctrl", 64'(out_ctrl), 64'd0);
        check("t3_rdy", 64'(in_ready), 64'd1);
        drive(0, '0, '0, 1);
        repeat (2) tick();

        // Stall accounting
        drive(1, 32'h77, 12'h5, 0);
        clr_cnt = 1;
        tick();
        clr_cnt = 0;
        drive(0, '0, '0, 0);
        repeat (5) tick();
        check("t4_stall5", 64'(stall_cnt), 64'd5);
        clr_cnt = 1;
        tick();
        clr_cnt = 0;
        check("t4_clr", 64'(stall_cnt), 64'd0);

        // Asynchronous reset while skidded
        drive(1, 32'h22, 12'h0F0, 0);
        tick();
        drive(0, '0, '0, 0);
        #1 rst = 1;
        #1;
        check("t5_valid", 64'(out_valid), 64'd0);
        check("t5_data", 64'(out_data), 64'd0);
        check("t5_ctrl", 64'(out_ctrl), 64'd0);
        check("t5_rdy", 64'(in_ready), 64'd1);
        check("t5_stall", 64'(stall_cnt), 64'd0);
        tick();
        rst = 0;
        drive(1, 32'h44, 12'h1, 1);
        tick();
        check("t5_first", 64'(out_data), 64'h44);
        drive(0, '0, '0, 1);
        tick();

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, 12'($urandom), $urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 15) == 0);
            clr_cnt = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush = 0; clr_cnt = 0;
        drive(0, '0, '0, 1);
        repeat (3) tick();
        check("drained", 64'(sb_q.size()), 64'd0);

        // Single-entry variant: combinational ready, replace-on-take, 4-bit counter
        z_in_valid = 1; z_in_data = 32'h55; z_in_ctrl = 12'h7; z_out_ready = 0;
        tick();
        z_in_data = 32'h66; z_in_ctrl = 12'h9;
        check("t6_rdy_low", 64'(z_in_ready), 64'd0);
        check("t6_data", 64'(z_out_data), 64'h55);
        check("t6_ctrl", 64'(z_out_ctrl), 64'h7);
        z_out_ready = 1;
        #1;
        check("t6_rdy_comb", 64'(z_in_ready), 64'd1);
        tick();
        check("t6_replace", 64'(z_out_data), 64'h66);
        check("t6_valid", 64'(z_out_valid), 64'd1);
        z_in_valid = 0; z_out_ready = 0; z_clr_cnt = 1;
        tick();
        z_clr_cnt = 0;
        check("t6_clr", 64'(z_stall_cnt), 64'd0);
        repeat (20) tick();
        check("t6_sat", 64'(z_stall_cnt), 64'd15);
        z_flush = 1;
        tick();
        z_flush = 0;
        check("t6_flush_valid", 64'(z_out_valid), 64'd0);
        check("t6_flush_ctrl", 64'(z_out_ctrl), 64'd0);
        check("t6_flush_rdy", 64'(z_in_ready), 64'd1);
        check("t6_flush_keeps_cnt", 64'(z_stall_cnt), 64'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipereg_hs.md
Name: pipereg_hs

Overview:
- Parametrised pipeline-stage register that replaces the fixed-field, flush-only stage registers.
- Carries an opaque payload plus a control field, with valid/ready handshaking on both sides.
- A 2-entry skid buffer keeps in_ready a pure register output, so backpressure does not form a combinational path through the stage.
- Drops in between any two stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB) and adds flush, stall accounting and bubble control-zeroing.

Parameters:
- DATA_W, 32: payload width (packed datapath fields: pc4, ALU out, store data, imm, rd, ...).
- CTRL_W, 12: control field width (dm_write, wr_en, dm_select, sel_data, to_OCM, ...); forced to 0 whenever the stage holds a bubble.
- SKID_EN, 1: 1 = 2-entry skid; 0 = single entry, in_ready = !out_valid || out_ready (combinational).
- CNT_W, 16: width of the saturating stall counter.

Ports:
- clk, input, 1: clock; all state changes on posedge.
- rst, input, 1: asynchronous, active-high reset.
- flush, input, 1: synchronous kill of all held entries.
- in_valid, input, 1: upstream entry valid.
- in_ready, output, 1: stage can accept an entry.
- in_data, input, DATA_W: upstream payload.
- in_ctrl, input, CTRL_W: upstream control.
- out_valid, output, 1: main entry valid.
- out_ready, input, 1: downstream accepts.
- out_data, output, DATA_W: main entry payload.
- out_ctrl, output, CTRL_W: main entry control; 0 when out_valid=0.
- stall_cnt, output, CNT_W: cycles where out_valid && !out_ready; saturates.
- clr_cnt, input, 1: synchronous clear of stall_cnt.

Behaviour:
- Reset (asynchronous, any cycle, including mid-transfer):
  - out_valid=0, out_data=0, out_ctrl=0, in_ready=1, stall_cnt=0, state EMPTY.
  - The skid entry is discarded.
- Handshakes: acc = in_valid && in_ready; take = out_valid && out_ready.
- State machine with SKID_EN=1 (internal registers: main, skid):
  - EMPTY:
    - acc -> FULL; main <= in on the next edge.
    - out_valid rises one cycle after acc; latency is 1 cycle.
  - FULL:
    - acc && take -> FULL; main <= in.
    - acc && !take -> SKIDDED; skid <= in; in_ready <= 0.
    - !acc && take -> EMPTY.
    - !acc && !take -> hold.
  - SKIDDED:
    - in_ready=0, so no acc is possible.
    - take -> FULL; main <= skid; in_ready <= 1.
    - !take -> hold.
- In FULL and SKIDDED, main data and ctrl are stable while !out_ready (AXI-style hold).
- Ordering is strict FIFO; no entry is ever dropped except by flush or reset.
- in_ready is a registered function of state: 1 in EMPTY and FULL, 0 in SKIDDED.
- flush:
  - Has priority over acc and take.
  - Next state EMPTY: out_valid <= 0, out_ctrl <= 0, in_ready <= 1.
  - out_data may keep its stale value; it is don't-care while invalid.
  - An entry presented with acc in the flush cycle is dropped.
  - A take in the flush cycle still counts as consumed downstream.
  - flush does not clear stall_cnt.
- SKID_EN=0:
  - Single entry; state is EMPTY or FULL only.
  - in_ready = !out_valid || out_ready, combinational.
- stall_cnt:
  - +1 per cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W-1 and never wraps.
  - clr_cnt has priority over increment; the counter reads 0 next cycle.
- Bubble rule: out_ctrl is gated to 0 whenever out_valid=0, so downstream write-enables can never fire from a bubble.
- in_data and in_ctrl are ignored when in_valid=0.

Decomposition:
- Shared constants include (alongside WORD_WIDTH, REGFILE_BITS):
  - 2-bit state encodings PHS_EMPTY=0, PHS_FULL=1, PHS_SKID=2.
  - Default field widths for each stage's packed payload and control.
- One sub-module, pipereg_hs_slot: DATA_W+CTRL_W register with load enable and async clear.
  - Instantiated twice (main, skid); the skid instance is generated only when SKID_EN=1.
- The FSM and the stall counter stay in the top module.

Test Plan:
1. Reset released, in_valid=1 with data 0xA5A5A5A5 and ctrl 0x3, out_ready=1 -> next cycle out_valid=1, out_data=0xA5A5A5A5, out_ctrl=0x3. Streaming 1,2,3 back-to-back -> outputs 1,2,3 with 1-cycle latency and in_ready held at 1.
2. FULL holding 0x11; out_ready=0; in 0x22 accepted -> in_ready=0 the next cycle and out_data stays 0x11. out_ready=1 for two cycles -> outputs 0x11 then 0x22, in_ready returns to 1, no loss or duplication.
3. SKIDDED (0x11 in main, 0x22 in skid); flush=1 with in_valid=1 (0x33) -> next cycle out_valid=0, out_ctrl=0, in_ready=1. 0x33 never appears at the output.
4. out_valid=1 with out_ready=0 for 5 cycles -> stall_cnt=5. clr_cnt together with a stall cycle -> stall_cnt=0. CNT_W=4 with 20 stall cycles -> stall_cnt=15.
5. rst asserted mid-cycle while SKIDDED -> outputs go to reset values immediately, without waiting for a clock edge. After release, a new entry 0x44 is output first, not 0x22.
6. SKID_EN=0: FULL with out_ready=0 -> in_ready=0 in the same cycle. Raise out_ready -> in_ready=1 combinationally, and a simultaneous accept and take replaces main.
